gray_seq_arbiter: RTL and testbench
===================================

# gray_seq_arbiter

Controller that shares one Gray-code sequencer between two requesters. Each requester submits a job (start value, length, direction); the block grants jobs round-robin, then emits the job's Gray codes one per accepted output beat on a valid/ready stream, tagged with the owning requester. It sits between the requesting logic and any consumer of Gray-coded count sequences.

## Interface
- WIDTH, 4, code width in bits; WIDTH >= 2.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; all state clears while low.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  requester 0 job accepted this cycle.
- req0_start  in  WIDTH  first binary count value.
- req0_len  in  WIDTH  number of codes; 0 encodes 2^WIDTH.
- req0_dir  in  1  1 = count up, 0 = count down.
- req1_valid, req1_ready, req1_start, req1_len, req1_dir: same as requester 0.
- out_valid  out  1  out_code valid.
- out_ready  in  1  consumer accepts the beat.
- out_code  out  WIDTH  Gray code, cnt ^ (cnt >> 1).
- out_id  out  1  requester owning the current job.
- out_last  out  1  current beat is the job's final code.
- busy  out  1  job in progress (state RUN).

## Operation
- Registers: state {IDLE, RUN}, cnt[WIDTH-1:0], rem[WIDTH:0], dir, id, rr (priority pointer).
- IDLE: winner = the only valid requester; if both are valid, winner = rr. reqN_ready = (state==IDLE) && winner==N && reqN_valid && reset high; combinational.
- Accept (ready && valid at an edge):
  - cnt <= start; dir <= req dir; id <= N.
  - rem <= len, or 2^WIDTH when len==0.
  - rr <= ~N; state <= RUN.
- RUN: out_valid=1, busy=1, out_last = (rem==1). No req_ready asserted.
- Beat (out_valid && out_ready):
  - If rem==1, state <= IDLE.
  - Otherwise cnt <= cnt±1 mod 2^WIDTH, rem <= rem-1.
- Wrap-around: up from 2^WIDTH-1 goes to 0; down from 0 goes to 2^WIDTH-1.
- Backpressure: while out_ready is low, out_code, out_id and out_last hold and nothing advances.
- Requesters hold valid and job fields stable until ready; fields are sampled only at the accept edge.
- out_code, out_id and out_last are driven from registers in every state; they are don't-care when out_valid=0.

## Timing
- Reset values: state IDLE, cnt 0, rem 0, id 0, rr 0. Outputs: out_valid 0, out_code 0, out_id 0, out_last 0, busy 0, req*_ready 0.
- Reset is asynchronous. Asserting it mid-job drops out_valid and busy immediately, without waiting for a clock edge. The partial job is discarded, not resumed.
- Latency: a job accepted at edge k presents its first code in the cycle after edge k, with out_valid high.
- Throughput: one code per cycle while out_ready stays high. A job of L codes occupies exactly L beats.
- Gap: the final beat at edge j returns to IDLE. The next job can be accepted at edge j+1, giving a minimum 1-cycle bubble on out_valid between jobs.
- Simultaneous requests: grants alternate 0,1,0,1 while both stay valid. A lone requester is granted regardless of rr.
- A request that arrives during RUN waits in IDLE arbitration; no request is dropped.

## Test plan
- Reset, then req0 start=0000 len=4 dir=1 with out_ready=1 → codes 0000,0001,0011,0010 on consecutive cycles; out_id=0; out_last only on 0010; busy falls after the last beat.
- req1 start=0001 len=3 dir=0 → codes 0001,0000,1000 (binary 1,0,15 across the wrap); out_id=1.
- req0 start=0000 len=0 dir=1 → 16 beats, each adjacent pair differs in exactly one bit; last code 1000 with out_last=1.
- Both requests valid and held after reset, each len=2 → job order 0,1,0,1; each reqN_ready is a single-cycle pulse; 1 bubble cycle between jobs.
- Mid-job, out_ready low for 3 cycles → out_code and out_last stay constant, out_valid stays 1; the sequence resumes with no code skipped or repeated.
- reset driven low between clock edges mid-job → out_valid=0 and busy=0 immediately. After release, req1 start=0101 len=1 → single code 0111 with out_last=1.

Source files
------------

// File: rtl/gray_seq_arbiter.sv
// Round-robin arbiter that grants one of two requesters a Gray-code job, then streams
// the job's codes on a valid/ready output tagged with the owning requester.
//
// Handshake: a transfer happens on every rising edge where valid and ready are both
// high; the producer holds valid and payload stable while valid && !ready.
module gray_seq_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_start,
    input  logic [WIDTH-1:0] req0_len,
    input  logic             req0_dir,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_start,
    input  logic [WIDTH-1:0] req1_len,
    input  logic             req1_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_code,
    output logic             out_id,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH:0]   rem;
    logic             dir;
    logic             id;
    logic             rr;

    logic             winner;
    logic             accept0;
    logic             accept1;
    logic             accept;
    logic             beat;
    logic             rem_one;
    logic             final_beat;
    logic [WIDTH-1:0] acc_start;
    logic [WIDTH-1:0] acc_len;
    logic             acc_dir;

    // A lone requester wins outright; rr only breaks ties.
    always_comb begin
        winner = rr;
        if (req0_valid && !req1_valid) begin
            winner = 1'b0;
        end else if (!req0_valid && req1_valid) begin
            winner = 1'b1;
        end
    end

    assign accept0    = (state == IDLE) && reset && req0_valid && (winner == 1'b0);
    assign accept1    = (state == IDLE) && reset && req1_valid && (winner == 1'b1);
    assign accept     = accept0 || accept1;
    assign beat       = (state == RUN) && out_ready;
    assign rem_one    = (rem == {{WIDTH{1'b0}}, 1'b1});
    assign final_beat = beat && rem_one;

    assign acc_start  = winner ? req1_start : req0_start;
    assign acc_len    = winner ? req1_len   : req0_len;
    assign acc_dir    = winner ? req1_dir   : req0_dir;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)     state_next = RUN;
            RUN:     if (final_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Job registers; a zero length encodes a full 2^WIDTH sweep, hence rem's extra bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            rem <= '0;
            dir <= 1'b0;
            id  <= 1'b0;
            rr  <= 1'b0;
        end else if (accept) begin
            cnt <= acc_start;
            rem <= (acc_len == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, acc_len};
            dir <= acc_dir;
            id  <= winner;
            rr  <= ~winner;
        end else if (beat && !final_beat) begin
            cnt <= dir ? cnt + 1'b1 : cnt - 1'b1;
            rem <= rem - 1'b1;
        end
    end

    always_comb begin
        req0_ready = accept0;
        req1_ready = accept1;
        out_valid  = (state == RUN);
        busy       = (state == RUN);
        out_code   = cnt ^ (cnt >> 1);
        out_id     = id;
        out_last   = rem_one;
    end

endmodule

// File: tb/tb_gray_seq_arbiter.sv
// Bench for gray_seq_arbiter: directed scenarios plus random jobs, checked against a
// queue-based model that expands each granted job into its expected Gray codes.
module tb_gray_seq_arbiter;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         req0_valid, req0_ready, req0_dir;
    logic         req1_valid, req1_ready, req1_dir;
    logic [W-1:0] req0_start, req0_len, req1_start, req1_len;
    logic         out_valid, out_ready, out_id, out_last, busy;
    logic [W-1:0] out_code;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    logic [W+1:0] exp_q[$];   // {id, last, code}
    logic [W:0]   got_q[$];   // {last, code} as observed
    int           grant_q[$];
    int           acc_cyc_q[$];
    bit           model_run = 0;
    bit           model_rr = 0;
    bit           rand_ready = 0;

    gray_seq_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_start(req0_start),
        .req0_len(req0_len), .req0_dir(req0_dir),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_start(req1_start),
        .req1_len(req1_len), .req1_dir(req1_dir),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_id(out_id), .out_last(out_last), .busy(busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Expand a job into its binary count sequence, then Gray-encode each value.
    function automatic void push_job(input int n, input logic [W-1:0] s, input logic [W-1:0] l,
                                     input logic d);
        int         len_i;
        int         b;
        logic [W-1:0] bv;
        len_i = (l == 0) ? (1 << W) : int'(l);
        for (int i = 0; i < len_i; i++) begin
            b  = (int'(s) + (d ? i : 2 * (1 << W) - i)) & ((1 << W) - 1);
            bv = b[W-1:0];
            exp_q.push_back({(n == 1), (i == len_i - 1), bv ^ (bv >> 1)});
        end
    endfunction

    // scoreboard: arbitration, status and every presented beat, sampled mid-cycle
    always @(negedge clk) begin : monitor
        logic e0, e1;
        logic [W+1:0] f;
        if (!reset) begin
            model_run = 0;
            model_rr  = 0;
            exp_q.delete();
        end else begin
            e0 = 0;
            e1 = 0;
            if (!model_run) begin
                if (req0_valid && (!req1_valid || !model_rr)) e0 = 1;
                else if (req1_valid) e1 = 1;
            end
            n_cmp++;
            if (req0_ready !== e0) begin
                n_bad++;
                $display("FAIL req0_ready cyc=%0d got=%b exp=%b", cyc, req0_ready, e0);
            end
            n_cmp++;
            if (req1_ready !== e1) begin
                n_bad++;
                $display("FAIL req1_ready cyc=%0d got=%b exp=%b", cyc, req1_ready, e1);
            end
            n_cmp++;
            if (out_valid !== model_run || busy !== model_run) begin
                n_bad++;
                $display("FAIL status cyc=%0d out_valid=%b busy=%b exp=%b", cyc, out_valid, busy,
                         model_run);
            end
            if (model_run) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL beat_unexpected cyc=%0d got code=%b exp none", cyc, out_code);
                    model_run = 0;
                end else begin
                    f = exp_q[0];
                    if ({out_id, out_last, out_code} !== f) begin
                        n_bad++;
                        $display("FAIL beat cyc=%0d got id/last/code=%b/%b/%b exp %b/%b/%b", cyc,
                                 out_id, out_last, out_code, f[W+1], f[W], f[W-1:0]);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got_q.push_back({out_last, out_code});
                        if (f[W]) model_run = 0;
                    end
                end
            end
            if (e0) begin
                push_job(0, req0_start, req0_len, req0_dir);
                grant_q.push_back(0);
                acc_cyc_q.push_back(cyc);
                model_run = 1;
                model_rr  = 1;
            end else if (e1) begin
                push_job(1, req1_start, req1_len, req1_dir);
                grant_q.push_back(1);
                acc_cyc_q.push_back(cyc);
                model_run = 1;
                model_rr  = 0;
            end
        end
    end

    // driver tasks
    task automatic set_req(input int n, input logic v, input logic [W-1:0] s,
                           input logic [W-1:0] l, input logic d);
        if (n == 0) begin
            req0_valid = v; req0_start = s; req0_len = l; req0_dir = d;
        end else begin
            req1_valid = v; req1_start = s; req1_len = l; req1_dir = d;
        end
    endtask

    task automatic drive_job(input int n, input logic [W-1:0] s, input logic [W-1:0] l,
                             input logic d, input bit chain);
        bit   acc;
        logic rdy;
        if (!chain) begin
            @(posedge clk);
            #1;
        end
        set_req(n, 1'b1, s, l, d);
        acc = 0;
        for (int c = 0; c < 500 && !acc; c++) begin
            @(negedge clk);
            rdy = (n == 0) ? req0_ready : req1_ready;
            if (rdy) acc = 1;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout req%0d got no ready exp ready within 500 cycles", n);
        end
        @(posedge clk);
        #1;
        set_req(n, 1'b0, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            #1;
            if (!model_run && exp_q.size() == 0 && !req0_valid && !req1_valid) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout got busy=%b pending=%0d exp idle", busy, exp_q.size());
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    // tests
    task automatic test_reset();
        reset = 1'b0;
        out_ready = 1'b1;
        set_req(0, 1'b1, 4'd3, 4'd2, 1'b1);
        set_req(1, 1'b1, 4'd5, 4'd2, 1'b0);
        #12;
        n_cmp++;
        if ({out_valid, busy, req0_ready, req1_ready, out_id, out_last} !== 6'b0 ||
            out_code !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_outputs got v/b/r0/r1/id/last=%b%b%b%b%b%b code=%b exp all 0",
                     out_valid, busy, req0_ready, req1_ready, out_id, out_last, out_code);
        end
        set_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
        set_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic test_directed();
        logic [W:0] e_a[4];
        logic [W:0] e_b[3];
        e_a = '{5'b00000, 5'b00001, 5'b00011, 5'b10010};
        e_b = '{5'b00001, 5'b00000, 5'b11000};
        got_q.delete();
        drive_job(0, 4'b0000, 4'd4, 1'b1, 0);
        wait_idle();
        n_cmp++;
        if (got_q.size() != 4) begin
            n_bad++;
            $display("FAIL up4_count got %0d exp 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got_q[i] !== e_a[i]) begin
                    n_bad++;
                    $display("FAIL up4_beat%0d got %b exp %b", i, got_q[i], e_a[i]);
                end
            end
        end
        got_q.delete();
        drive_job(1, 4'b0001, 4'd3, 1'b0, 0);
        wait_idle();
        n_cmp++;
        if (got_q.size() != 3) begin
            n_bad++;
            $display("FAIL down_wrap_count got %0d exp 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (got_q[i] !== e_b[i]) begin
                    n_bad++;
                    $display("FAIL down_wrap_beat%0d got %b exp %b", i, got_q[i], e_b[i]);
                end
            end
        end
        got_q.delete();
        drive_job(0, 4'b0000, 4'd0, 1'b1, 0);
        wait_idle();
        n_cmp++;
        if (got_q.size() != 16) begin
            n_bad++;
            $display("FAIL full_count got %0d exp 16", got_q.size());
        end else begin
            for (int i = 1; i < 16; i++) begin
                n_cmp++;
                if ($countones(got_q[i][W-1:0] ^ got_q[i-1][W-1:0]) != 1) begin
                    n_bad++;
                    $display("FAIL full_onebit%0d got %b->%b exp one bit change", i,
                             got_q[i-1][W-1:0], got_q[i][W-1:0]);
                end
            end
            n_cmp++;
            if (got_q[15] !== 5'b11000) begin
                n_bad++;
                $display("FAIL full_last got %b exp 11000", got_q[15]);
            end
        end
    endtask

    task automatic test_alternation();
        int e_g[4];
        e_g = '{0, 1, 0, 1};
        apply_reset();
        grant_q.delete();
        acc_cyc_q.delete();
        @(posedge clk);
        #1;
        fork
            begin
                drive_job(0, 4'd3, 4'd2, 1'b1, 1);
                drive_job(0, 4'd7, 4'd2, 1'b0, 1);
            end
            begin
                drive_job(1, 4'd9, 4'd2, 1'b1, 1);
                drive_job(1, 4'd12, 4'd2, 1'b0, 1);
            end
        join
        wait_idle();
        n_cmp++;
        if (grant_q.size() != 4) begin
            n_bad++;
            $display("FAIL alt_grants got %0d grants exp 4", grant_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (grant_q[i] != e_g[i]) begin
                    n_bad++;
                    $display("FAIL alt_order%0d got %0d exp %0d", i, grant_q[i], e_g[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (acc_cyc_q[i] - acc_cyc_q[i-1] != 3) begin
                    n_bad++;
                    $display("FAIL alt_gap%0d got %0d cycles exp 3", i,
                             acc_cyc_q[i] - acc_cyc_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] hold_code;
        logic         hold_last;
        got_q.delete();
        drive_job(0, 4'd10, 4'd8, 1'b1, 0);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        hold_code = '0;
        hold_last = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            if (k == 0) begin
                hold_code = out_code;
                hold_last = out_last;
            end
            n_cmp++;
            if (out_valid !== 1'b1 || out_code !== hold_code || out_last !== hold_last) begin
                n_bad++;
                $display("FAIL stall%0d got v/code/last=%b/%b/%b exp 1/%b/%b", k, out_valid,
                         out_code, out_last, hold_code, hold_last);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();
        n_cmp++;
        if (got_q.size() != 8 || got_q[got_q.size()-1] !== 5'b10001) begin
            n_bad++;
            $display("FAIL stall_total got %0d beats exp 8 ending 10001", got_q.size());
        end
    endtask

    task automatic test_async_reset();
        drive_job(0, 4'd2, 4'd10, 1'b1, 0);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset got out_valid=%b busy=%b exp 0/0", out_valid, busy);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        got_q.delete();
        drive_job(1, 4'b0101, 4'd1, 1'b0, 0);
        wait_idle();
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== 5'b10111) begin
            n_bad++;
            $display("FAIL post_reset_job got %0d beats first=%b exp 1 beat 10111", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 5'b0);
        end
    endtask

    task automatic test_random();
        int total;
        total = 0;
        got_q.delete();
        rand_ready = 1;
        fork
            for (int j = 0; j < 12; j++) begin
                logic [W-1:0] s, l;
                s = W'($urandom);
                l = W'($urandom);
                total += (l == 0) ? 16 : int'(l);
                repeat ($urandom_range(0, 4)) @(posedge clk);
                drive_job(0, s, l, 1'($urandom), 0);
            end
            for (int j = 0; j < 12; j++) begin
                logic [W-1:0] s, l;
                s = W'($urandom);
                l = W'($urandom);
                total += (l == 0) ? 16 : int'(l);
                repeat ($urandom_range(0, 4)) @(posedge clk);
                drive_job(1, s, l, 1'($urandom), 0);
            end
        join
        rand_ready = 0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_idle();
        n_cmp++;
        if (got_q.size() != total) begin
            n_bad++;
            $display("FAIL random_total got %0d beats exp %0d", got_q.size(), total);
        end
    endtask

    initial begin
        reset = 1'b0;
        out_ready = 1'b1;
        req0_valid = 1'b0; req0_start = '0; req0_len = '0; req0_dir = 1'b0;
        req1_valid = 1'b0; req1_start = '0; req1_len = '0; req1_dir = 1'b0;
        test_reset();
        test_directed();
        test_alternation();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
